// File: rtl/fifo_rr_drain.sv
// Round-robin drain of N first-word-fall-through FIFOs into one registered output,
// taking up to BURST consecutive words from a source before rotating.
module fifo_rr_drain #(
    parameter int B     = 8,
    parameter int N     = 4,
    parameter int SW    = 2,
    parameter int BURST = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    empty,
    input  logic [N*B-1:0]  r_data,
    output logic [N-1:0]    rd,
    output logic [B-1:0]    out_data,
    output logic [SW-1:0]   out_src,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [SW-1:0] cur;
    logic [4:0]    cnt;
    logic          act;

    logic          load;
    logic          gnt_vld;
    logic          gnt_cont;
    logic [SW-1:0] gnt;
    logic [B-1:0]  gnt_data;

    assign load = ~out_valid | out_ready;

    // Grant selection: stay on the owner mid-burst, otherwise search cur+1 .. cur (mod N).
    always_comb begin
        int idx;
        gnt_vld  = 1'b0;
        gnt_cont = 1'b0;
        gnt      = cur;
        idx      = 0;
        if (act && !empty[cur] && (cnt < 5'(BURST - 1))) begin
            gnt_vld  = 1'b1;
            gnt_cont = 1'b1;
        end else begin
            // Descending scan so the nearest eligible index after cur wins.
            for (int k = N; k >= 1; k--) begin
                idx = (int'(cur) + k) % N;
                if (!empty[idx]) begin
                    gnt_vld = 1'b1;
                    gnt     = SW'(idx);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt == SW'(i)) gnt_data = r_data[i*B +: B];
        end
    end

    always_comb begin
        rd = '0;
        if (!reset && load && gnt_vld) rd[gnt] = 1'b1;
    end

    // Output register and arbitration state
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            cur       <= SW'(N - 1);
            cnt       <= '0;
            act       <= 1'b0;
        end else if (load) begin
            if (gnt_vld) begin
                out_data  <= gnt_data;
                out_src   <= gnt;
                out_valid <= 1'b1;
                act       <= 1'b1;
                if (gnt_cont) begin
                    cnt <= cnt + 5'd1;
                end else begin
                    cur <= gnt;
                    cnt <= '0;
                end
            end else begin
                out_valid <= 1'b0;
                act       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Testbench for fifo_rr_drain: table-driven grant order, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fifo_rr_drain;

    localparam int B     = 8;
    localparam int N     = 4;
    localparam int SW    = 2;
    localparam int BURST = 2;

    logic            clk;
    logic            reset;
    logic [N-1:0]    empty;
    logic [N*B-1:0]  r_data;
    logic [N-1:0]    rd;
    logic [B-1:0]    out_data;
    logic [SW-1:0]   out_src;
    logic            out_valid;
    logic            out_ready;

    fifo_rr_drain #(.B(B), .N(N), .SW(SW), .BURST(BURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .empty     (empty),
        .r_data    (r_data),
        .rd        (rd),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Source FIFO contents (front = next word presented)
    logic [B-1:0] q [N][$];

    // Reference model: output word plus the current burst described as
    // owner / words already taken in this burst / whether the burst is alive.
    logic         m_valid;
    logic [B-1:0] m_data;
    int           m_src;
    int           m_owner;
    int           m_run;
    logic         m_alive;

    logic [N-1:0] last_rd;

    typedef struct {
        logic [N-1:0]  exp_rd;
        logic          exp_valid;
        logic [SW-1:0] exp_src;
        logic [B-1:0]  exp_data;
    } vec_t;
    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            empty[i] = (q[i].size() == 0);
            r_data[i*B +: B] = (q[i].size() != 0) ? q[i][0] : 8'hEE;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_owner = N - 1;
        m_run   = 0;
        m_alive = 1'b0;
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) q[i].delete();
    endtask

    // One clock: apply inputs, check the pop strobes, clock, check the registered output.
    task automatic cycle(input logic rst, input logic rdy);
        int g;
        logic cont;
        logic [N-1:0] exp_rd;
        reset = rst;
        out_ready = rdy;
        drive_src();
        #1;
        g = -1;
        cont = 1'b0;
        if (!rst && (!m_valid || rdy)) begin
            if (m_alive && q[m_owner].size() != 0 && m_run < BURST) begin
                g = m_owner;
                cont = 1'b1;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_owner + k) % N;
                    if (g < 0 && q[idx].size() != 0) g = idx;
                end
            end
        end
        exp_rd = (g >= 0) ? N'(1 << g) : '0;
        check("rd", 32'(rd), 32'(exp_rd));
        check("rd_while_empty", 32'(rd & empty), 32'd0);
        last_rd = rd;
        if (rst) begin
            model_reset();
        end else if (!m_valid || rdy) begin
            if (g >= 0) begin
                m_data  = q[g][0];
                m_src   = g;
                m_valid = 1'b1;
                m_alive = 1'b1;
                if (cont) begin
                    m_run++;
                end else begin
                    m_owner = g;
                    m_run   = 1;
                end
            end else begin
                m_valid = 1'b0;
                m_alive = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (g >= 0) void'(q[g].pop_front());
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_src", 32'(out_src), 32'(m_src));
        end
    endtask

    task automatic preload(input int src, input int cnt_w);
        for (int k = 0; k < cnt_w; k++) q[src].push_back(B'(src * 16 + k));
    endtask

    initial begin
        logic [B-1:0] held_d;
        logic [SW-1:0] held_s;
        int words2;

        reset = 1'b1;
        out_ready = 1'b0;
        empty = '1;
        r_data = '0;
        clear_q();
        model_reset();

        // Expected grant order with 3 words per source, out_ready held high
        tbl[0]  = '{4'b0001, 1'b1, 2'd0, 8'h00};
        tbl[1]  = '{4'b0001, 1'b1, 2'd0, 8'h01};
        tbl[2]  = '{4'b0010, 1'b1, 2'd1, 8'h10};
        tbl[3]  = '{4'b0010, 1'b1, 2'd1, 8'h11};
        tbl[4]  = '{4'b0100, 1'b1, 2'd2, 8'h20};
        tbl[5]  = '{4'b0100, 1'b1, 2'd2, 8'h21};
        tbl[6]  = '{4'b1000, 1'b1, 2'd3, 8'h30};
        tbl[7]  = '{4'b1000, 1'b1, 2'd3, 8'h31};
        tbl[8]  = '{4'b0001, 1'b1, 2'd0, 8'h02};
        tbl[9]  = '{4'b0010, 1'b1, 2'd1, 8'h12};
        tbl[10] = '{4'b0100, 1'b1, 2'd2, 8'h22};
        tbl[11] = '{4'b1000, 1'b1, 2'd3, 8'h32};
        tbl[12] = '{4'b0000, 1'b0, 2'd0, 8'h00};

        // All sources empty after reset
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_out_src", 32'(out_src), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1);
            check("idle_out_data", 32'(out_data), 32'd0);
        end

        // Table-driven burst/rotation order
        cycle(1'b1, 1'b1);
        for (int s = 0; s < N; s++) preload(s, 3);
        for (int i = 0; i < 13; i++) begin
            cycle(1'b0, 1'b1);
            check("tbl_rd", 32'(last_rd), 32'(tbl[i].exp_rd));
            check("tbl_valid", 32'(out_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check("tbl_src", 32'(out_src), 32'(tbl[i].exp_src));
                check("tbl_data", 32'(out_data), 32'(tbl[i].exp_data));
            end
        end

        // Single non-empty source keeps being re-granted
        cycle(1'b1, 1'b1);
        clear_q();
        preload(2, 5);
        words2 = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1);
            if (out_valid && out_src == 2'd2) words2++;
        end
        check("src2_words", 32'(words2), 32'd5);
        check("src2_drained_valid", 32'(out_valid), 32'd0);

        // Back-pressure holds the word and pops nothing
        cycle(1'b1, 1'b1);
        clear_q();
        for (int s = 0; s < N; s++) preload(s, 3);
        cycle(1'b0, 1'b1);
        held_d = out_data;
        held_s = out_src;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0);
            check("stall_rd", 32'(last_rd), 32'd0);
            check("stall_data", 32'(out_data), 32'(held_d));
            check("stall_src", 32'(out_src), 32'(held_s));
        end
        cycle(1'b0, 1'b1);
        check("release_one_pop", 32'($countones(last_rd)), 32'd1);

        // Owner runs dry mid-burst: rotate to next eligible, fresh burst there
        cycle(1'b1, 1'b1);
        clear_q();
        preload(1, 1);
        preload(3, 3);
        cycle(1'b0, 1'b1);
        check("dry_first_src", 32'(out_src), 32'd1);
        cycle(1'b0, 1'b1);
        check("dry_rotate_src", 32'(out_src), 32'd3);
        cycle(1'b0, 1'b1);
        check("dry_burst_cont", 32'(out_src), 32'd3);
        cycle(1'b0, 1'b1);
        check("dry_burst_end", 32'(out_src), 32'd3);

        // Reset pulse during a source-0 burst with a held word
        cycle(1'b1, 1'b1);
        clear_q();
        preload(0, 3);
        preload(2, 2);
        cycle(1'b0, 1'b1);
        check("rstmid_src0", 32'(out_src), 32'd0);
        cycle(1'b1, 1'b0);
        check("rstmid_no_rd", 32'(last_rd), 32'd0);
        check("rstmid_valid", 32'(out_valid), 32'd0);
        cycle(1'b0, 1'b1);
        check("rstmid_lowest", 32'(out_src), 32'd0);

        // Randomized traffic against the reference model
        cycle(1'b1, 1'b1);
        clear_q();
        for (int i = 0; i < 3000; i++) begin
            for (int s = 0; s < N; s++) begin
                if (q[s].size() < 6 && $urandom_range(0, 3) == 0)
                    q[s].push_back(B'($urandom));
            end
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
